counter_seq_monitor: RTL and testbench

- Downstream checker for the 2-bit mode-select counter (`counters`).
- Samples the counter's {q1,q0} output and its {s1,s0} mode selects on every rising clock edge.
- Predicts each next value from a golden model and flags any mismatch; an error flag stays set until cleared.
- Counts wrap-arounds and reports them to the status/debug logic that sits above the counter.

---
 rtl/counter_seq_monitor_pkg.sv | 12 +
 rtl/counter_seq_monitor_if.sv | 32 +++
 rtl/counter_seq_monitor_next_model.sv | 18 +
 rtl/counter_seq_monitor.sv | 91 +++++++++
 tb/tb_counter_seq_monitor.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/counter_seq_monitor_pkg.sv
// counter_mon_pkg: mode encodings, monitor states and direction helper shared by counter_seq_monitor.
// Optional capture logic elsewhere is enabled with COUNTER_MON_CAPTURE_EN.
package counter_mon_pkg;
   localparam logic [1:0] MODE_UP4 = 2'b00;
   localparam logic [1:0] MODE_DN4 = 2'b01;
   localparam logic [1:0] MODE_UP3 = 2'b10;
   localparam logic [1:0] MODE_DN3 = 2'b11;
   typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, ERROR = 2'd2} state_t;
   function automatic logic is_up(input logic [1:0] mode);
      return (mode == MODE_UP4) || (mode == MODE_UP3);
   endfunction
endpackage

// File: rtl/counter_seq_monitor_if.sv
// counter_seq_monitor_if: counter observation inputs and monitor status outputs.
// Capture outputs exist only when COUNTER_MON_CAPTURE_EN is defined.
interface counter_seq_monitor_if #(parameter int WRAP_W = 8);
   logic s1;
   logic s0;
   logic q1;
   logic q0;
   logic clear;
   logic [1:0] exp_q;
   logic err;
   logic err_pulse;
   logic wrap_pulse;
   logic [WRAP_W-1:0] wrap_count;
   logic tracking;
`ifdef COUNTER_MON_CAPTURE_EN
   logic [1:0] cap_exp;
   logic [1:0] cap_act;
   logic [1:0] cap_mode;
   logic cap_valid;
   modport master (output s1, s0, q1, q0, clear,
                   input exp_q, err, err_pulse, wrap_pulse, wrap_count, tracking,
                   input cap_exp, cap_act, cap_mode, cap_valid);
   modport slave (input s1, s0, q1, q0, clear,
                  output exp_q, err, err_pulse, wrap_pulse, wrap_count, tracking,
                  output cap_exp, cap_act, cap_mode, cap_valid);
`else
   modport master (output s1, s0, q1, q0, clear,
                   input exp_q, err, err_pulse, wrap_pulse, wrap_count, tracking);
   modport slave (input s1, s0, q1, q0, clear,
                  output exp_q, err, err_pulse, wrap_pulse, wrap_count, tracking);
`endif
endinterface

// File: rtl/counter_seq_monitor_next_model.sv
// counter_next_model: golden next value of the 2-bit mode-select counter.
module counter_next_model
   import counter_mon_pkg::*;
(
   input  logic [1:0] i_q,
   input  logic [1:0] i_mode,
   output logic [1:0] o_next
);
   logic [1:0] w_up3;
   logic [1:0] w_dn3;
   always_comb begin
      w_up3 = (i_q >= 2'd2) ? 2'd0 : i_q + 2'd1;
      w_dn3 = (i_q == 2'd1) ? 2'd0 : (i_q == 2'd2) ? 2'd1 : 2'd2;
      o_next = (i_mode == MODE_UP4) ? i_q + 2'd1 :
               (i_mode == MODE_DN4) ? i_q - 2'd1 :
               (i_mode == MODE_UP3) ? w_up3 : w_dn3;
   end
endmodule

// File: rtl/counter_seq_monitor.sv
// counter_seq_monitor: checks each counter sample against the golden next value and counts wraps.
// Define COUNTER_MON_CAPTURE_EN to record expected/actual/mode of the first mismatch.
module counter_seq_monitor
   import counter_mon_pkg::*;
#(
   parameter int WRAP_W = 8
) (
   input logic clock,
   input logic reset,
   counter_seq_monitor_if.slave bus
);
   logic [1:0] w_q;
   logic [1:0] w_mode;
   logic [1:0] w_pred;
   logic [1:0] w_exp;
   logic w_mis;
   logic w_wrap;
   state_t r_state;
   logic [1:0] r_prev_q;
   logic [1:0] r_prev_mode;
   logic [1:0] r_exp;
   logic r_err;
   logic r_err_pulse;
   logic r_wrap_pulse;
   logic [WRAP_W-1:0] r_wrap_count;
   assign w_q = {bus.q1, bus.q0};
   assign w_mode = {bus.s1, bus.s0};
   // the counter stepped using the mode seen at the previous edge
   counter_next_model u_pred (.i_q(r_prev_q), .i_mode(r_prev_mode), .o_next(w_pred));
   counter_next_model u_exp (.i_q(w_q), .i_mode(w_mode), .o_next(w_exp));
   assign w_mis = (r_state != IDLE) && (w_q != w_pred);
   assign w_wrap = (r_state != IDLE) &&
                   (is_up(r_prev_mode) ? (r_prev_q >= 2'd2 && w_q == 2'd0)
                                       : (r_prev_q == 2'd0 && w_q >= 2'd2));
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_prev_q <= 2'd0;
         r_prev_mode <= 2'd0;
         r_exp <= 2'd0;
         r_err <= 1'b0;
         r_err_pulse <= 1'b0;
         r_wrap_pulse <= 1'b0;
         r_wrap_count <= '0;
      end else begin
         r_state <= (r_state == IDLE || bus.clear) ? TRACK : (w_mis ? ERROR : r_state);
         r_prev_q <= w_q;
         r_prev_mode <= w_mode;
         r_exp <= w_exp;
         r_err <= !bus.clear && (r_err || w_mis);
         r_err_pulse <= w_mis;
         r_wrap_pulse <= w_wrap;
         r_wrap_count <= bus.clear ? '0 :
                         (w_wrap && r_wrap_count != {WRAP_W{1'b1}}) ? r_wrap_count + 1'b1 : r_wrap_count;
      end
   end
   assign bus.exp_q = r_exp;
   assign bus.err = r_err;
   assign bus.err_pulse = r_err_pulse;
   assign bus.wrap_pulse = r_wrap_pulse;
   assign bus.wrap_count = r_wrap_count;
   assign bus.tracking = (r_state != IDLE);
`ifdef COUNTER_MON_CAPTURE_EN
   logic [1:0] r_cap_exp;
   logic [1:0] r_cap_act;
   logic [1:0] r_cap_mode;
   logic r_cap_valid;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cap_exp <= 2'd0;
         r_cap_act <= 2'd0;
         r_cap_mode <= 2'd0;
         r_cap_valid <= 1'b0;
      end else if (bus.clear) begin
         r_cap_exp <= 2'd0;
         r_cap_act <= 2'd0;
         r_cap_mode <= 2'd0;
         r_cap_valid <= 1'b0;
      end else if (w_mis && !r_cap_valid) begin
         r_cap_exp <= w_pred;
         r_cap_act <= w_q;
         r_cap_mode <= r_prev_mode;
         r_cap_valid <= 1'b1;
      end
   end
   assign bus.cap_exp = r_cap_exp;
   assign bus.cap_act = r_cap_act;
   assign bus.cap_mode = r_cap_mode;
   assign bus.cap_valid = r_cap_valid;
`endif
endmodule

// File: tb/tb_counter_seq_monitor.sv
// tb_counter_seq_monitor: vector table, reset/saturation sequences and random stimulus vs a behavioural model.
// Capture outputs are also checked when COUNTER_MON_CAPTURE_EN is defined.
module tb_counter_seq_monitor;
   localparam int W = 2;
   localparam int WMAX = (1 << W) - 1;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   counter_seq_monitor_if #(.WRAP_W(W)) bus ();
   counter_seq_monitor #(.WRAP_W(W)) dut (.clock(clock), .reset(reset), .bus(bus));
   int n_chk = 0;
   int n_pass = 0;
   int m_trk, m_pq, m_pm, m_exp, m_err, m_ep, m_wp, m_wc;
   int m_cexp, m_cact, m_cmode, m_cv;
   typedef struct {
      int q; int m; bit clr;
      int exp; int err; int ep; int wp; int wc;
   } vec_t;
   vec_t tbl[21];
   function automatic int gold(input int q, input int m);
      case (m)
         0: return (q + 1) % 4;
         1: return (q + 3) % 4;
         2: return (q == 3) ? 0 : (q + 1) % 3;
         default: return (q == 3) ? 2 : (q + 2) % 3;
      endcase
   endfunction
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask
   task automatic model_reset();
      {m_trk, m_pq, m_pm, m_exp, m_err, m_ep, m_wp, m_wc} = '0;
      {m_cexp, m_cact, m_cmode, m_cv} = '0;
   endtask
   task automatic model_edge(input int q, input int m, input bit clr);
      int mis, wrap;
      mis = 0;
      wrap = 0;
      if (m_trk != 0) begin
         mis = (q != gold(m_pq, m_pm)) ? 1 : 0;
         wrap = (m_pm % 2 == 0) ? ((m_pq >= 2 && q == 0) ? 1 : 0) : ((m_pq == 0 && q >= 2) ? 1 : 0);
      end
      if (clr) begin
         {m_cexp, m_cact, m_cmode, m_cv} = '0;
      end else if (mis != 0 && m_cv == 0) begin
         m_cexp = gold(m_pq, m_pm);
         m_cact = q;
         m_cmode = m_pm;
         m_cv = 1;
      end
      m_ep = mis;
      m_wp = wrap;
      m_err = clr ? 0 : ((m_err != 0 || mis != 0) ? 1 : 0);
      m_wc = clr ? 0 : ((wrap != 0 && m_wc < WMAX) ? m_wc + 1 : m_wc);
      m_exp = gold(q, m);
      m_pq = q;
      m_pm = m;
      m_trk = 1;
   endtask
   task automatic drive_edge(input int q, input int m, input bit clr);
      {bus.q1, bus.q0} = q[1:0];
      {bus.s1, bus.s0} = m[1:0];
      bus.clear = clr;
      @(posedge clock);
      model_edge(q, m, clr);
      #1;
   endtask
   task automatic check_cap();
`ifdef COUNTER_MON_CAPTURE_EN
      chk("cap_exp", bus.cap_exp, m_cexp);
      chk("cap_act", bus.cap_act, m_cact);
      chk("cap_mode", bus.cap_mode, m_cmode);
      chk("cap_valid", bus.cap_valid, m_cv);
`endif
   endtask
   task automatic check_model();
      chk("exp_q", bus.exp_q, m_exp);
      chk("err", bus.err, m_err);
      chk("err_pulse", bus.err_pulse, m_ep);
      chk("wrap_pulse", bus.wrap_pulse, m_wp);
      chk("wrap_count", bus.wrap_count, m_wc);
      chk("tracking", bus.tracking, m_trk);
      check_cap();
   endtask
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_model();
      #2 reset = 1'b1;
   endtask
   initial begin
      int lq, lm;
      tbl[0]  = '{0, 0, 0, 1, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 2, 0, 0, 0, 0};
      tbl[2]  = '{2, 0, 0, 3, 0, 0, 0, 0};
      tbl[3]  = '{3, 0, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 1, 0, 0, 1, 1};
      tbl[5]  = '{1, 1, 0, 0, 0, 0, 0, 1};
      tbl[6]  = '{0, 1, 0, 3, 0, 0, 0, 1};
      tbl[7]  = '{3, 1, 0, 2, 0, 0, 1, 2};
      tbl[8]  = '{2, 1, 0, 1, 0, 0, 0, 2};
      tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 2};
      tbl[10] = '{0, 1, 0, 3, 0, 0, 0, 2};
      tbl[11] = '{3, 2, 0, 0, 0, 0, 1, 3};
      tbl[12] = '{0, 2, 0, 1, 0, 0, 1, 3};
      tbl[13] = '{1, 2, 0, 2, 0, 0, 0, 3};
      tbl[14] = '{2, 2, 0, 0, 0, 0, 0, 3};
      tbl[15] = '{0, 2, 0, 1, 0, 0, 1, 3};
      tbl[16] = '{1, 3, 0, 0, 0, 0, 0, 3};
      tbl[17] = '{1, 3, 0, 0, 1, 1, 0, 3};
      tbl[18] = '{0, 3, 0, 2, 1, 0, 0, 3};
      tbl[19] = '{0, 3, 1, 2, 0, 1, 0, 0};
      tbl[20] = '{2, 3, 0, 1, 0, 0, 1, 1};
      {bus.s1, bus.s0, bus.q1, bus.q0, bus.clear} = '0;
      #1 reset = 1'b0;
      #1;
      model_reset();
      chk("rst_exp_q", bus.exp_q, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_wrap_count", bus.wrap_count, 0);
      chk("rst_tracking", bus.tracking, 0);
      check_model();
      repeat (2) @(posedge clock);
      #4 reset = 1'b1;
      for (int i = 0; i < 21; i++) begin
         drive_edge(tbl[i].q, tbl[i].m, tbl[i].clr);
         chk($sformatf("tbl%0d_exp_q", i), bus.exp_q, tbl[i].exp);
         chk($sformatf("tbl%0d_err", i), bus.err, tbl[i].err);
         chk($sformatf("tbl%0d_err_pulse", i), bus.err_pulse, tbl[i].ep);
         chk($sformatf("tbl%0d_wrap_pulse", i), bus.wrap_pulse, tbl[i].wp);
         chk($sformatf("tbl%0d_wrap_count", i), bus.wrap_count, tbl[i].wc);
         chk($sformatf("tbl%0d_tracking", i), bus.tracking, 1);
         check_cap();
      end
      drive_edge(0, 3, 0);
      chk("mid_err_set", bus.err, 1);
      do_reset();
      chk("mid_rst_err", bus.err, 0);
      chk("mid_rst_tracking", bus.tracking, 0);
      drive_edge(3, 0, 0);
      chk("ref_no_compare", bus.err_pulse, 0);
      chk("ref_tracking", bus.tracking, 1);
      check_model();
      for (int i = 0; i < 17; i++) begin
         drive_edge((i + 4) % 4, 0, 0);
         check_model();
      end
      chk("wrap_sat", bus.wrap_count, 3);
      chk("sat_err", bus.err, 0);
      lq = 0;
      lm = 0;
      for (int i = 0; i < 800; i++) begin
         int q, m;
         bit c;
         if ($urandom_range(0, 99) < 2) begin
            do_reset();
            lq = $urandom_range(0, 3);
         end
         m = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : lm;
         q = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : gold(lq, lm);
         c = ($urandom_range(0, 15) == 0);
         drive_edge(q, m, c);
         check_model();
         lq = q;
         lm = m;
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
